riscv_load_store_datapath: RTL and testbench
============================================

Name: riscv_load_store_datapath

Overview:
- Single-cycle load/store execute slice for the RISCV softcore.
- Decodes a 32-bit RV32I instruction into fields and all five immediate formats.
- Computes the effective address with a 3-bit-controlled ALU (rs1 + immediate).
- Accesses a byte-addressable data memory with byte, halfword and word lanes selected by funct3.
- Sits between the register file (rs1/rs2 data in, load data out) and the program counter logic.

Parameters:
- DEPTH, 256, data memory size in 32-bit words; power of two, at least 4. ADDR_W = clog2(DEPTH).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  synchronous, active-low reset.
- instruction_i  in  32  instruction word.
- alu_control_i  in  3  ALU operation select.
- rs1_data_i  in  32  register-file read data 1.
- rs2_data_i  in  32  register-file read data 2 (store data).
- opcode_o  out  7  instr[6:0].
- funct3_o  out  3  instr[14:12].
- funct7_o  out  7  instr[31:25].
- rs1_o  out  5  instr[19:15].
- rs2_o  out  5  instr[24:20].
- rd_o  out  5  instr[11:7].
- immediate_i_o  out  32  I-type immediate, sign-extended.
- immediate_s_o  out  32  S-type immediate, sign-extended.
- immediate_u_o  out  32  U-type immediate.
- immediate_b_o  out  32  B-type immediate.
- immediate_j_o  out  32  J-type immediate.
- alu_result_o  out  32  effective address / ALU result.
- alu_zero_o  out  1  high when alu_result_o == 0.
- reg_write_o  out  1  register-file write enable.
- mem_write_o  out  1  memory write enable (qualified).
- load_data_o  out  32  extended load data.

Behaviour:
- Decode is purely combinational using standard RV32I fields:
  - I = sext(instr[31:20]).
  - S = sext({instr[31:25], instr[11:7]}).
  - U = {instr[31:12], 12'b0}.
  - B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- Control:
  - opcode[5] = 1 (store): reg_write_o = 0, ALU operand B = immediate_s, store request = 1.
  - opcode[5] = 0 (load): reg_write_o = 1, operand B = immediate_i, store request = 0.
- ALU operand A = rs1_data_i. Results wrap modulo 2^32. alu_control_i encoding:
  - 000: AND.
  - 001: OR.
  - 010: ADD.
  - 110: SUB.
  - 111: SLT signed (result 1 or 0).
  - All other codes: result 0.
- Word index = alu_result_o[ADDR_W+1:2]. Addresses beyond the memory wrap modulo DEPTH words.
- Reads are combinational from the current memory contents.
- Load funct3:
  - 000 LB: byte lane addr[1:0], sign-extended.
  - 001 LH: halfword lane addr[1], sign-extended.
  - 010 LW: full word; addr[1:0] ignored.
  - 100 LBU: byte lane, zero-extended.
  - 101 LHU: halfword lane, zero-extended.
  - 011, 110, 111: load_data_o = 0.
- Lanes are little-endian: byte 0 is bits [7:0].
- Store funct3 (writes on the rising edge when mem_write_o = 1):
  - 000 SB: write rs2_data_i[7:0] into the addressed byte lane only.
  - 001 SH: write rs2_data_i[15:0] into halfword lane addr[1].
  - 010 SW: write all 32 bits.
  - Any other funct3: mem_write_o = 0, no write.
- Reset: while reset_i = 0 at a rising edge, every memory word is cleared to 0 and no store occurs in that cycle.
- Decode and ALU outputs do not depend on reset. After reset, all loads return 0.
- Read-during-write: load_data_o shows the old contents until the edge and the new contents after it.
- Hard requirement (misaligned, without the optional feature): halfword accesses ignore addr[0] and word accesses ignore addr[1:0]. No fault is raised.

Optional Feature:
- Macro: MISALIGN_CHECK_EN.
- When defined:
  - Adds output misaligned_o (1 bit).
  - misaligned_o is high for a halfword access with addr[0] = 1, or a word access with addr[1:0] != 0.
  - When high, mem_write_o = 0 (store suppressed) and load_data_o = 0.
- When not defined: no port, and the hard requirement above applies.

Test Plan:
- Reset with reset_i = 0 for one edge; LW at 0x108 -> load_data_o = 0x00000000.
- rs1 = 0x100, rs2 = 0x80FF7F12, alu_control_i = 010, instr 0x0020A423 (SW x2,8(x1)):
  - Decode: alu_result_o = 0x108, mem_write_o = 1, reg_write_o = 0, immediate_s_o = 8.
  - After the edge, instr 0x0080A183 (LW) -> load_data_o = 0x80FF7F12.
- Same memory, rs1 = 0x100:
  - LB 9 (0x00908183) -> 0x0000007F.
  - LB 10 -> 0xFFFFFFFF.
  - LBU 11 (funct3 100) -> 0x00000080.
  - LH 10 -> 0xFFFF80FF.
  - LHU 10 -> 0x000080FF.
- SB with rs2 = 0xAA at 0x109, then LW 0x108 -> 0x80FFAA12 (other bytes preserved).
- ALU with rs1 = 5, operand 7:
  - SUB -> 0xFFFFFFFE, alu_zero_o = 0.
  - SLT -> 1.
  - AND -> 5.
  - OR -> 7.
  - Code 011 -> 0, alu_zero_o = 1.
- Store with funct3 011 -> mem_write_o = 0 and memory unchanged. Address 0x108 + 4*DEPTH aliases to 0x108.

Source files
------------

// File: rtl/riscv_load_store_datapath.sv
// riscv_load_store_datapath: single-cycle load/store execute slice.
// Decodes an RV32I instruction, forms rs1 + immediate in a small ALU and
// accesses a byte-lane data memory of DEPTH 32-bit words.
// Optional build macro MISALIGN_CHECK_EN adds misaligned_o; a misaligned
// access then suppresses the store and forces load data to zero.
module riscv_load_store_datapath #(
   parameter int DEPTH = 256
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [31:0] instruction_i,
   input  logic [2:0]  alu_control_i,
   input  logic [31:0] rs1_data_i,
   input  logic [31:0] rs2_data_i,
   output logic [6:0]  opcode_o,
   output logic [2:0]  funct3_o,
   output logic [6:0]  funct7_o,
   output logic [4:0]  rs1_o,
   output logic [4:0]  rs2_o,
   output logic [4:0]  rd_o,
   output logic [31:0] immediate_i_o,
   output logic [31:0] immediate_s_o,
   output logic [31:0] immediate_u_o,
   output logic [31:0] immediate_b_o,
   output logic [31:0] immediate_j_o,
   output logic [31:0] alu_result_o,
   output logic        alu_zero_o,
   output logic        reg_write_o,
   output logic        mem_write_o,
   output logic [31:0] load_data_o
`ifdef MISALIGN_CHECK_EN
   ,
   output logic        misaligned_o
`endif
);

   localparam int ADDR_W = $clog2(DEPTH);

   logic [31:0]       mem_q [DEPTH];
   logic [31:0]       wr_word_d;
   logic [31:0]       operand_b;
   logic [31:0]       rd_word;
   logic [15:0]       rd_half;
   logic [7:0]        rd_byte;
   logic [ADDR_W-1:0] word_idx;
   logic [1:0]        byte_off;
   logic              store_req;
   logic              store_ok;
   logic              misal;

   assign opcode_o = instruction_i[6:0];
   assign funct3_o = instruction_i[14:12];
   assign funct7_o = instruction_i[31:25];
   assign rs1_o    = instruction_i[19:15];
   assign rs2_o    = instruction_i[24:20];
   assign rd_o     = instruction_i[11:7];

   assign immediate_i_o = {{20{instruction_i[31]}}, instruction_i[31:20]};
   assign immediate_s_o = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
   assign immediate_u_o = {instruction_i[31:12], 12'b0};
   assign immediate_b_o = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                           instruction_i[30:25], instruction_i[11:8], 1'b0};
   assign immediate_j_o = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                           instruction_i[20], instruction_i[30:21], 1'b0};

   // opcode bit 5 separates STORE (0100011) from LOAD (0000011)
   assign store_req   = opcode_o[5];
   assign reg_write_o = ~store_req;
   assign operand_b   = store_req ? immediate_s_o : immediate_i_o;

   // effective-address ALU
   always_comb begin
      case (alu_control_i)
         3'b000:  alu_result_o = rs1_data_i & operand_b;
         3'b001:  alu_result_o = rs1_data_i | operand_b;
         3'b010:  alu_result_o = rs1_data_i + operand_b;
         3'b110:  alu_result_o = rs1_data_i - operand_b;
         3'b111:  alu_result_o = {31'b0, ($signed(rs1_data_i) < $signed(operand_b))};
         default: alu_result_o = 32'b0;
      endcase
   end

   assign alu_zero_o = (alu_result_o == 32'b0);

   // upper address bits are dropped so out-of-range addresses alias
   assign word_idx = alu_result_o[ADDR_W+1:2];
   assign byte_off = alu_result_o[1:0];
   assign rd_word  = mem_q[word_idx];
   assign rd_half  = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
   assign rd_byte  = rd_word[{byte_off, 3'b000} +: 8];

`ifdef MISALIGN_CHECK_EN
   assign misal = (((funct3_o == 3'b001) || (funct3_o == 3'b101)) && byte_off[0]) ||
                  ((funct3_o == 3'b010) && (byte_off != 2'b00));
   assign misaligned_o = misal;
`else
   assign misal = 1'b0;
`endif

   assign store_ok    = (funct3_o == 3'b000) || (funct3_o == 3'b001) || (funct3_o == 3'b010);
   assign mem_write_o = store_req & store_ok & ~misal;

   // load lane select and extension
   always_comb begin
      load_data_o = 32'b0;
      if (!misal) begin
         case (funct3_o)
            3'b000:  load_data_o = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_data_o = {{16{rd_half[15]}}, rd_half};
            3'b010:  load_data_o = rd_word;
            3'b100:  load_data_o = {24'b0, rd_byte};
            3'b101:  load_data_o = {16'b0, rd_half};
            default: load_data_o = 32'b0;
         endcase
      end
   end

   // merge store data into the addressed word, other lanes kept
   always_comb begin
      wr_word_d = rd_word;
      case (funct3_o)
         3'b000:  wr_word_d[{byte_off, 3'b000} +: 8] = rs2_data_i[7:0];
         3'b001:  wr_word_d[{byte_off[1], 4'b0000} +: 16] = rs2_data_i[15:0];
         3'b010:  wr_word_d = rs2_data_i;
         default: wr_word_d = rd_word;
      endcase
   end

   // data memory: synchronous clear on reset, otherwise qualified write
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         for (int k = 0; k < DEPTH; k++) begin
            mem_q[k] <= 32'b0;
         end
      end else if (mem_write_o) begin
         mem_q[word_idx] <= wr_word_d;
      end
   end

endmodule

// File: tb/tb_riscv_load_store_datapath.sv
// Scoreboard bench for riscv_load_store_datapath: a driver issues one
// instruction per cycle and queues the expected response from a byte-array
// memory model; a negedge monitor pops and compares.
module tb_riscv_load_store_datapath;

   localparam int DEPTH = 256;
   localparam int MEM_BYTES = 4 * DEPTH;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b0;
   logic [31:0] instruction_i = '0;
   logic [2:0]  alu_control_i = 3'b010;
   logic [31:0] rs1_data_i = '0;
   logic [31:0] rs2_data_i = '0;
   logic [6:0]  opcode_o;
   logic [2:0]  funct3_o;
   logic [6:0]  funct7_o;
   logic [4:0]  rs1_o, rs2_o, rd_o;
   logic [31:0] immediate_i_o, immediate_s_o, immediate_u_o, immediate_b_o, immediate_j_o;
   logic [31:0] alu_result_o;
   logic        alu_zero_o, reg_write_o, mem_write_o;
   logic [31:0] load_data_o;
`ifdef MISALIGN_CHECK_EN
   logic        misaligned_o;
`endif

   riscv_load_store_datapath #(.DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .instruction_i(instruction_i),
      .alu_control_i(alu_control_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
      .opcode_o(opcode_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
      .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
      .immediate_i_o(immediate_i_o), .immediate_s_o(immediate_s_o),
      .immediate_u_o(immediate_u_o), .immediate_b_o(immediate_b_o),
      .immediate_j_o(immediate_j_o), .alu_result_o(alu_result_o),
      .alu_zero_o(alu_zero_o), .reg_write_o(reg_write_o),
      .mem_write_o(mem_write_o), .load_data_o(load_data_o)
`ifdef MISALIGN_CHECK_EN
      , .misaligned_o(misaligned_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] imm_i, imm_s, imm_u, imm_b, imm_j;
      logic [31:0] res;
      logic        zero, rw, mw, misal;
      logic [31:0] ld;
      bit          chk_ld;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  mm [MEM_BYTES];
   int          n_chk = 0;
   int          n_err = 0;
   int          n_push = 0;
   int          n_pop = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] alu_ref(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      case (c)
         3'b000: return a & b;
         3'b001: return a | b;
         3'b010: return a + b;
         3'b110: return a - b;
         3'b111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int unsigned baddr(input logic [31:0] a);
      return int'(a % MEM_BYTES);
   endfunction

   function automatic logic [31:0] load_ref(input logic [2:0] f3, input logic [31:0] a);
      int unsigned b  = baddr(a);
      int unsigned h  = b - (b % 2);
      int unsigned w  = b - (b % 4);
      logic [15:0] hv = {mm[h + 1], mm[h]};
      case (f3)
         3'b000: return {{24{mm[b][7]}}, mm[b]};
         3'b001: return {{16{hv[15]}}, hv};
         3'b010: return {mm[w + 3], mm[w + 2], mm[w + 1], mm[w]};
         3'b100: return {24'b0, mm[b]};
         3'b101: return {16'b0, hv};
         default: return 32'd0;
      endcase
   endfunction

   task automatic store_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      int unsigned b = baddr(a);
      int unsigned h = b - (b % 2);
      int unsigned w = b - (b % 4);
      case (f3)
         3'b000: mm[b] = d[7:0];
         3'b001: begin mm[h] = d[7:0]; mm[h + 1] = d[15:8]; end
         3'b010: for (int i = 0; i < 4; i++) mm[w + i] = d[8*i +: 8];
         default: ;
      endcase
   endtask

   function automatic logic [31:0] mk_ld(input logic [2:0] f3, input logic [11:0] imm);
      return {imm, 5'd1, f3, 5'd3, 7'b0000011};
   endfunction

   function automatic logic [31:0] mk_st(input logic [2:0] f3, input logic [11:0] imm);
      return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], 7'b0100011};
   endfunction

   // drive one instruction for one cycle and queue its expected response
   task automatic issue(input logic [31:0] instr, input logic [2:0] ctl, input logic [31:0] a,
                        input logic [31:0] d, input logic rst, input bit use_k, input logic [31:0] k);
      exp_t e;
      logic [31:0] ob;
      logic [2:0]  f3;
      @(posedge clk_i);
      #1;
      instruction_i = instr; alu_control_i = ctl; rs1_data_i = a; rs2_data_i = d; reset_i = rst;
      f3 = instr[14:12];
      e.instr = instr;
      e.imm_i = {{20{instr[31]}}, instr[31:20]};
      e.imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      e.imm_u = {instr[31:12], 12'b0};
      e.imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      e.imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      ob      = instr[5] ? e.imm_s : e.imm_i;
      e.res   = alu_ref(ctl, a, ob);
      e.zero  = (e.res == 0);
      e.rw    = !instr[5];
`ifdef MISALIGN_CHECK_EN
      e.misal = ((f3 == 3'b001 || f3 == 3'b101) && (e.res % 2 != 0)) ||
                (f3 == 3'b010 && (e.res % 4 != 0));
`else
      e.misal = 1'b0;
`endif
      e.mw     = instr[5] && (f3 <= 3'd2) && !e.misal;
      e.ld     = e.misal ? 32'd0 : (use_k ? k : load_ref(f3, e.res));
      e.chk_ld = 1'b1;
      exp_q.push_back(e);
      n_push++;
      if (!rst) begin
         for (int i = 0; i < MEM_BYTES; i++) mm[i] = 8'h00;
      end else if (e.mw) begin
         store_ref(f3, e.res, d);
      end
   endtask

   // monitor: compare whatever the DUT presents against the queued response
   always @(negedge clk_i) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_pop++;
         chk("opcode", {25'b0, opcode_o}, {25'b0, e.instr[6:0]});
         chk("funct3", {29'b0, funct3_o}, {29'b0, e.instr[14:12]});
         chk("funct7", {25'b0, funct7_o}, {25'b0, e.instr[31:25]});
         chk("rs1", {27'b0, rs1_o}, {27'b0, e.instr[19:15]});
         chk("rs2", {27'b0, rs2_o}, {27'b0, e.instr[24:20]});
         chk("rd", {27'b0, rd_o}, {27'b0, e.instr[11:7]});
         chk("imm_i", immediate_i_o, e.imm_i);
         chk("imm_s", immediate_s_o, e.imm_s);
         chk("imm_u", immediate_u_o, e.imm_u);
         chk("imm_b", immediate_b_o, e.imm_b);
         chk("imm_j", immediate_j_o, e.imm_j);
         chk("alu_result", alu_result_o, e.res);
         chk("alu_zero", {31'b0, alu_zero_o}, {31'b0, e.zero});
         chk("reg_write", {31'b0, reg_write_o}, {31'b0, e.rw});
         chk("mem_write", {31'b0, mem_write_o}, {31'b0, e.mw});
`ifdef MISALIGN_CHECK_EN
         chk("misaligned", {31'b0, misaligned_o}, {31'b0, e.misal});
`endif
         if (e.chk_ld) chk("load_data", load_data_o, e.ld);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] instr, a;
      logic [2:0]  ctl;
      reset_i = 1'b0;
      repeat (2) @(posedge clk_i);
      for (int i = 0; i < MEM_BYTES; i++) mm[i] = 8'h00;
      // after reset all loads read zero
      issue(mk_ld(3'b010, 12'd8), 3'b010, 32'h100, 32'h0, 1'b1, 1'b1, 32'h0);
      // SW then read-back and lane extraction
      issue(32'h0020A423, 3'b010, 32'h100, 32'h80FF7F12, 1'b1, 1'b0, 32'h0);
      issue(32'h0080A183, 3'b010, 32'h100, 32'h0, 1'b1, 1'b1, 32'h80FF7F12);
      issue(32'h00908183, 3'b010, 32'h100, 32'h0, 1'b1, 1'b1, 32'h0000007F);
      issue(mk_ld(3'b000, 12'd10), 3'b010, 32'h100, 32'h0, 1'b1, 1'b1, 32'hFFFFFFFF);
      issue(mk_ld(3'b100, 12'd11), 3'b010, 32'h100, 32'h0, 1'b1, 1'b1, 32'h00000080);
      issue(mk_ld(3'b001, 12'd10), 3'b010, 32'h100, 32'h0, 1'b1, 1'b1, 32'hFFFF80FF);
      issue(mk_ld(3'b101, 12'd10), 3'b010, 32'h100, 32'h0, 1'b1, 1'b1, 32'h000080FF);
      issue(mk_st(3'b000, 12'd9), 3'b010, 32'h100, 32'h000000AA, 1'b1, 1'b0, 32'h0);
      issue(mk_ld(3'b010, 12'd8), 3'b010, 32'h100, 32'h0, 1'b1, 1'b1, 32'h80FFAA12);
      // ALU operations with rs1 = 5, immediate 7
      issue(mk_ld(3'b010, 12'd7), 3'b110, 32'd5, 32'h0, 1'b1, 1'b0, 32'h0);
      issue(mk_ld(3'b010, 12'd7), 3'b111, 32'd5, 32'h0, 1'b1, 1'b0, 32'h0);
      issue(mk_ld(3'b010, 12'd7), 3'b000, 32'd5, 32'h0, 1'b1, 1'b0, 32'h0);
      issue(mk_ld(3'b010, 12'd7), 3'b001, 32'd5, 32'h0, 1'b1, 1'b0, 32'h0);
      issue(mk_ld(3'b010, 12'd7), 3'b011, 32'd5, 32'h0, 1'b1, 1'b0, 32'h0);
      // invalid store width leaves memory alone; aliased address reads same word
      issue(mk_st(3'b011, 12'd8), 3'b010, 32'h100, 32'h12345678, 1'b1, 1'b0, 32'h0);
      issue(mk_ld(3'b010, 12'd8), 3'b010, 32'h100 + 4 * DEPTH, 32'h0, 1'b1, 1'b1, 32'h80FFAA12);
      // SH into upper halfword lane
      issue(mk_st(3'b001, 12'd10), 3'b010, 32'h100, 32'h0000BEEF, 1'b1, 1'b0, 32'h0);
      issue(mk_ld(3'b010, 12'd8), 3'b010, 32'h100, 32'h0, 1'b1, 1'b1, 32'hBEEFAA12);
      // randomized traffic with a reset in the middle
      for (int n = 0; n < 400; n++) begin
         instr = $urandom;
         instr[6:0] = ($urandom_range(0, 1) == 1) ? 7'b0100011 : 7'b0000011;
         ctl = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b010;
         a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 3 * MEM_BYTES));
         issue(instr, ctl, a, $urandom, (n == 200) ? 1'b0 : 1'b1, 1'b0, 32'h0);
      end
      issue(mk_ld(3'b010, 12'd8), 3'b010, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0);
      issue(mk_ld(3'b010, 12'd8), 3'b010, 32'h100, 32'h0, 1'b1, 1'b1, 32'h0);
      repeat (3) @(posedge clk_i);
      chk("scoreboard_drained", n_pop, n_push);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
